adc_scan_sequencer: RTL and testbench

Sequencer for the 8-channel phototransistor front end. It steps the external analog mux through all channels and waits a settling time on each. It then runs a start/done handshake with the 8-bit ADC, captures each result into the per-channel sample bank and computes the per-frame minimum. Once per completed scan it publishes the darkest channel and the goalie-move decision to the processor-visible goalie word logic.

---
 rtl/adc_scan_sequencer_if.sv | 21 ++
 rtl/adc_scan_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_scan_sequencer_if.sv
// ADC handshake and sample-bank write port of the phototransistor scan sequencer.
// The sequencer is the master; the ADC/mux/sample-bank side is the slave.
interface adc_scan_sequencer_if;
    logic [2:0] mux_addr;
    logic       adc_start;
    logic [7:0] adc_data;
    logic       adc_done;
    logic       sample_we;
    logic [2:0] sample_addr;
    logic [7:0] sample_data;

    modport master (
        output mux_addr, adc_start, sample_we, sample_addr, sample_data,
        input  adc_data, adc_done
    );

    modport slave (
        input  mux_addr, adc_start, sample_we, sample_addr, sample_data,
        output adc_data, adc_done
    );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Scans the phototransistor channels through the analog mux, converts each one,
// writes the results to the sample bank and publishes the darkest channel and
// the goalie-move decision once per completed frame.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | parked on channel 0, waiting for enable
// SETTLE     | mux address held while the analog front end settles
// START      | adc_start asserted for START_CYCLES cycles
// CONVERT    | waiting for synchronized done, bounded by CONV_TIMEOUT
// CAPTURE    | sample_we strobe, running minimum update
// NEXT       | advance channel or finish the frame
// FRAME_DONE | frame result visible, frame_valid pulse
module adc_scan_sequencer #(
    parameter int NUM_CH        = 8,
    parameter int SETTLE_CYCLES = 1000,
    parameter int START_CYCLES  = 4,
    parameter int CONV_TIMEOUT  = 20000,
    parameter int THRESHOLD     = 80
) (
    input  logic                 CLK100MHZ,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic                 clear_err,
    adc_scan_sequencer_if.master adc,
    output logic                 frame_valid,
    output logic [2:0]           min_addr,
    output logic [7:0]           min_val,
    output logic                 move_goalie,
    output logic                 timeout_err
);

    localparam int MAX_A   = (SETTLE_CYCLES > START_CYCLES) ? SETTLE_CYCLES : START_CYCLES;
    localparam int MAX_CNT = (MAX_A > CONV_TIMEOUT) ? MAX_A : CONV_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LOAD  = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONV_LOAD   = CNT_W'(CONV_TIMEOUT - 1);
    localparam logic [2:0]       LAST_CH     = 3'(NUM_CH - 1);
    // One bit wider than the sample so a threshold of 256 still compares correctly.
    localparam logic [8:0]       THRESH      = 9'(THRESHOLD);

    typedef enum logic [2:0] {
        IDLE, SETTLE, START, CONVERT, CAPTURE, NEXT, FRAME_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic [2:0]       ch, ch_nxt;
    logic             timer_tc;
    logic             conv_done, conv_timeout, commit;

    logic             done_meta, done_sync;
    logic             cap_valid;
    logic [7:0]       run_min;
    logic [2:0]       run_idx;
    logic             run_valid;

    assign timer_tc      = (timer == '0);
    assign adc.mux_addr  = ch;
    assign adc.adc_start = (state == START);
    assign adc.sample_we = (state == CAPTURE);
    assign frame_valid   = (state == FRAME_DONE);

    // State, channel and down-counter registers.
    always_ff @(posedge CLK100MHZ) begin
        if (!resetn) begin
            state <= IDLE;
            timer <= '0;
            ch    <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            ch    <= ch_nxt;
        end
    end

    // Next-state, timer reload and event decode.
    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        ch_nxt       = ch;
        conv_done    = 1'b0;
        conv_timeout = 1'b0;
        commit       = 1'b0;
        case (state)
            IDLE: begin
                ch_nxt = '0;
                if (enable) begin
                    state_nxt = SETTLE;
                    timer_nxt = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (timer_tc) begin
                    state_nxt = START;
                    timer_nxt = START_LOAD;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            START: begin
                if (timer_tc) begin
                    state_nxt = CONVERT;
                    timer_nxt = CONV_LOAD;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            CONVERT: begin
                // A done arriving on the last allowed cycle still counts as valid.
                if (done_sync) begin
                    conv_done = 1'b1;
                    state_nxt = CAPTURE;
                end else if (timer_tc) begin
                    conv_timeout = 1'b1;
                    state_nxt    = CAPTURE;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            CAPTURE: state_nxt = NEXT;
            NEXT: begin
                if (ch == LAST_CH) begin
                    state_nxt = FRAME_DONE;
                    commit    = 1'b1;
                end else begin
                    ch_nxt    = ch + 3'd1;
                    state_nxt = SETTLE;
                    timer_nxt = SETTLE_LOAD;
                end
            end
            FRAME_DONE: begin
                ch_nxt = '0;
                if (enable) begin
                    state_nxt = SETTLE;
                    timer_nxt = SETTLE_LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Done synchronizer, sample capture, running minimum, frame commit and error flag.
    always_ff @(posedge CLK100MHZ) begin
        if (!resetn) begin
            done_meta       <= 1'b0;
            done_sync       <= 1'b0;
            adc.sample_addr <= '0;
            adc.sample_data <= '0;
            cap_valid       <= 1'b0;
            run_min         <= 8'hFF;
            run_idx         <= '0;
            run_valid       <= 1'b0;
            min_addr        <= '0;
            min_val         <= 8'hFF;
            move_goalie     <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            done_meta <= adc.adc_done;
            done_sync <= done_meta;

            if (conv_done || conv_timeout) begin
                adc.sample_data <= conv_done ? adc.adc_data : 8'hFF;
                adc.sample_addr <= ch;
                cap_valid       <= conv_done;
            end

            // First channel seeds the minimum; later ones need a valid, strictly smaller
            // value, or a valid value when everything so far has timed out.
            if (state == CAPTURE) begin
                if ((ch == '0) ||
                    (cap_valid && (!run_valid || (adc.sample_data < run_min)))) begin
                    run_min   <= adc.sample_data;
                    run_idx   <= ch;
                    run_valid <= cap_valid;
                end
            end

            if (commit) begin
                min_val     <= run_min;
                min_addr    <= run_idx;
                move_goalie <= run_valid && ({1'b0, run_min} < THRESH);
            end

            if (conv_timeout) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer: a table of frames with hand-computed
// results plus sequences for reset, enable drop and reset mid-conversion.
module tb_adc_scan_sequencer;

    localparam int SETTLE    = 4;
    localparam int START     = 2;
    localparam int TIMEOUT   = 50;
    localparam int DONE_DLY  = 10;
    localparam int DONE_HOLD = 4;
    // CONVERT lasts from adc_start falling until done clears the synchronizer and is acted on.
    localparam int CONV_OK   = DONE_DLY - START + 3;
    localparam int CH_TIME   = SETTLE + START + CONV_OK + 2;
    localparam int FRAME_T   = 8 * CH_TIME + 1;

    logic       clk;
    logic       resetn;
    logic       enable;
    logic       clear_err;
    logic       frame_valid;
    logic [2:0] min_addr;
    logic [7:0] min_val;
    logic       move_goalie;
    logic       timeout_err;

    adc_scan_sequencer_if bus ();

    adc_scan_sequencer #(
        .NUM_CH(8), .SETTLE_CYCLES(SETTLE), .START_CYCLES(START),
        .CONV_TIMEOUT(TIMEOUT), .THRESHOLD(80)
    ) dut (
        .CLK100MHZ  (clk),
        .resetn     (resetn),
        .enable     (enable),
        .clear_err  (clear_err),
        .adc        (bus.master),
        .frame_valid(frame_valid),
        .min_addr   (min_addr),
        .min_val    (min_val),
        .move_goalie(move_goalie),
        .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [0:7][7:0] data;
        logic [7:0]      mask;
        logic [2:0]      exp_addr;
        logic [7:0]      exp_val;
        logic            exp_move;
        logic            exp_err;
    } vec_t;

    vec_t vecs [8];

    int n_checks = 0;
    int n_fail   = 0;

    logic [0:7][7:0] model_data;
    logic [7:0]      withhold_mask;

    int         start_cnt [8];
    int         conv_len  [8];
    int         conv_run;
    int         fv_count;
    logic [2:0] we_addr_q [$];
    logic [7:0] we_data_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ADC model: done rises DONE_DLY cycles after adc_start rises, held DONE_HOLD cycles.
    initial begin
        int  cnt;
        int  hold;
        logic start_prev;
        cnt = 0;
        hold = 0;
        start_prev = 1'b0;
        bus.adc_done = 1'b0;
        bus.adc_data = 8'd0;
        forever begin
            @(negedge clk);
            if (bus.adc_start === 1'b1 && !start_prev) begin
                cnt = DONE_DLY;
                hold = 0;
                bus.adc_done = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && !withhold_mask[bus.mux_addr]) begin
                    bus.adc_done = 1'b1;
                    bus.adc_data = model_data[bus.mux_addr];
                    hold = DONE_HOLD;
                end
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) bus.adc_done = 1'b0;
            end
            start_prev = (bus.adc_start === 1'b1);
        end
    end

    // Output monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.adc_start === 1'b1) begin
                start_cnt[bus.mux_addr]++;
                conv_run = 0;
            end else if (bus.sample_we === 1'b1) begin
                conv_len[bus.sample_addr] = conv_run;
                we_addr_q.push_back(bus.sample_addr);
                we_data_q.push_back(bus.sample_data);
            end else begin
                conv_run++;
            end
            if (frame_valid === 1'b1) fv_count++;
        end
    end

    task automatic mon_reset();
        @(posedge clk);
        #1;
        for (int c = 0; c < 8; c++) begin
            start_cnt[c] = 0;
            conv_len[c]  = 0;
        end
        conv_run = 0;
        fv_count = 0;
        we_addr_q.delete();
        we_data_q.delete();
    endtask

    task automatic set_vec(input int i, input logic [0:7][7:0] d, input logic [7:0] m,
                           input logic [2:0] a, input logic [7:0] v, input logic mv, input logic e);
        vecs[i].data = d;
        vecs[i].mask = m;
        vecs[i].exp_addr = a;
        vecs[i].exp_val = v;
        vecs[i].exp_move = mv;
        vecs[i].exp_err = e;
    endtask

    // Waits for frame_valid; optionally drops enable once mux_addr reaches drop_ch.
    task automatic wait_frame(input int drop_ch, output int cycles, output bit seen);
        cycles = 0;
        seen = 1'b0;
        while (cycles < 3000 && !seen) begin
            @(negedge clk);
            cycles++;
            if (int'(bus.mux_addr) == drop_ch) enable = 1'b0;
            if (frame_valid === 1'b1) seen = 1'b1;
        end
        check("frame_valid_seen", 32'(seen), 32'd1);
    endtask

    // Strobe order/data, start widths and conversion lengths for one frame.
    task automatic check_strobes(input logic [0:7][7:0] d, input logic [7:0] m);
        check("we_count", 32'(we_addr_q.size()), 32'd8);
        for (int c = 0; c < 8; c++) begin
            if (c < we_addr_q.size()) begin
                check($sformatf("we_addr[%0d]", c), 32'(we_addr_q[c]), 32'(c));
                check($sformatf("we_data[%0d]", c), 32'(we_data_q[c]),
                      m[c] ? 32'hFF : 32'(d[c]));
            end
            check($sformatf("start_width[%0d]", c), 32'(start_cnt[c]), 32'(START));
            check($sformatf("conv_len[%0d]", c), 32'(conv_len[c]), m[c] ? 32'(TIMEOUT) : 32'(CONV_OK));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  seen;
        bit  saw_start;
        int  guard;

        set_vec(0, {8'd120, 8'd90, 8'd200, 8'd60, 8'd75, 8'd150, 8'd60, 8'd255}, 8'h00, 3'd3, 8'd60,  1'b1, 1'b0);
        set_vec(1, {8'd80, 8'd80, 8'd80, 8'd80, 8'd80, 8'd80, 8'd80, 8'd80},     8'h00, 3'd0, 8'd80,  1'b0, 1'b0);
        set_vec(2, {8'd100, 8'd110, 8'd30, 8'd90, 8'd85, 8'd120, 8'd200, 8'd99}, 8'h04, 3'd4, 8'd85,  1'b0, 1'b1);
        set_vec(3, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8},             8'hFF, 3'd0, 8'hFF,  1'b0, 1'b1);
        set_vec(4, {8'd80, 8'd80, 8'd80, 8'd80, 8'd80, 8'd80, 8'd80, 8'd79},     8'h00, 3'd7, 8'd79,  1'b1, 1'b0);
        set_vec(5, {8'd10, 8'd200, 8'd150, 8'd180, 8'd160, 8'd170, 8'd190, 8'd140}, 8'h01, 3'd7, 8'd140, 1'b0, 1'b1);
        set_vec(6, {8'd90, 8'd90, 8'd40, 8'd90, 8'd90, 8'd90, 8'd40, 8'd90},     8'h00, 3'd2, 8'd40,  1'b1, 1'b0);
        set_vec(7, {8'd5, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255},   8'h80, 3'd1, 8'd0,   1'b1, 1'b1);

        model_data = '0;
        withhold_mask = 8'h00;
        resetn = 1'b0;
        enable = 1'b1;
        clear_err = 1'b0;
        mon_reset();

        // Reset held with enable high: no start pulse, all outputs at reset values.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_adc_start", 32'(bus.adc_start), 32'd0);
        end
        check("reset_mux_addr", 32'(bus.mux_addr), 32'd0);
        check("reset_sample_we", 32'(bus.sample_we), 32'd0);
        check("reset_sample_addr", 32'(bus.sample_addr), 32'd0);
        check("reset_sample_data", 32'(bus.sample_data), 32'd0);
        check("reset_frame_valid", 32'(frame_valid), 32'd0);
        check("reset_min_addr", 32'(min_addr), 32'd0);
        check("reset_min_val", 32'(min_val), 32'hFF);
        check("reset_move_goalie", 32'(move_goalie), 32'd0);
        check("reset_timeout_err", 32'(timeout_err), 32'd0);
        enable = 1'b0;
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_adc_start", 32'(bus.adc_start), 32'd0);

        // Table-driven single frames, each started and then left to finish with enable low.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            model_data = vecs[i].data;
            withhold_mask = vecs[i].mask;
            if (i > 0) check("timeout_err_sticky", 32'(timeout_err), 32'(vecs[i-1].exp_err));
            clear_err = 1'b1;
            @(negedge clk);
            clear_err = 1'b0;
            check("clear_err", 32'(timeout_err), 32'd0);
            mon_reset();
            @(negedge clk);
            enable = 1'b1;
            @(negedge clk);
            enable = 1'b0;
            wait_frame(-1, cyc, seen);
            check($sformatf("v%0d_min_addr", i), 32'(min_addr), 32'(vecs[i].exp_addr));
            check($sformatf("v%0d_min_val", i), 32'(min_val), 32'(vecs[i].exp_val));
            check($sformatf("v%0d_move_goalie", i), 32'(move_goalie), 32'(vecs[i].exp_move));
            check($sformatf("v%0d_timeout_err", i), 32'(timeout_err), 32'(vecs[i].exp_err));
            repeat (30) @(negedge clk);
            check_strobes(vecs[i].data, vecs[i].mask);
            check("frame_valid_pulses", 32'(fv_count), 32'd1);
            check("idle_adc_start", 32'(bus.adc_start), 32'd0);
            check("idle_mux_addr", 32'(bus.mux_addr), 32'd0);
        end

        // Continuous scan, then enable dropped while on channel 4 of the second frame.
        @(negedge clk);
        model_data = vecs[0].data;
        withhold_mask = 8'h00;
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        mon_reset();
        @(negedge clk);
        enable = 1'b1;
        wait_frame(-1, cyc, seen);
        wait_frame(4, cyc, seen);
        check("frame_period", 32'(cyc), 32'(FRAME_T));
        check("drop_enable_low", 32'(enable), 32'd0);
        check("drop_min_addr", 32'(min_addr), 32'd3);
        check("drop_min_val", 32'(min_val), 32'd60);
        check("drop_move_goalie", 32'(move_goalie), 32'd1);
        repeat (30) @(negedge clk);
        check("drop_we_count", 32'(we_addr_q.size()), 32'd16);
        if (we_addr_q.size() == 16) check("drop_last_addr", 32'(we_addr_q[15]), 32'd7);
        check("drop_frame_pulses", 32'(fv_count), 32'd2);
        check("drop_idle_adc_start", 32'(bus.adc_start), 32'd0);
        check("drop_idle_mux_addr", 32'(bus.mux_addr), 32'd0);

        // Reset during CONVERT of channel 5, with a timeout already flagged on channel 1.
        @(negedge clk);
        withhold_mask = 8'h02;
        mon_reset();
        @(negedge clk);
        enable = 1'b1;
        saw_start = 1'b0;
        guard = 0;
        while (guard < 3000) begin
            @(negedge clk);
            guard++;
            if (bus.mux_addr == 3'd5 && bus.adc_start === 1'b1) saw_start = 1'b1;
            if (saw_start && bus.adc_start === 1'b0) break;
        end
        check("reached_ch5_convert", 32'(saw_start), 32'd1);
        check("pre_reset_timeout_err", 32'(timeout_err), 32'd1);
        resetn = 1'b0;
        withhold_mask = 8'h00;
        @(negedge clk);
        check("rst5_mux_addr", 32'(bus.mux_addr), 32'd0);
        check("rst5_adc_start", 32'(bus.adc_start), 32'd0);
        check("rst5_sample_we", 32'(bus.sample_we), 32'd0);
        check("rst5_sample_addr", 32'(bus.sample_addr), 32'd0);
        check("rst5_sample_data", 32'(bus.sample_data), 32'd0);
        check("rst5_frame_valid", 32'(frame_valid), 32'd0);
        check("rst5_min_addr", 32'(min_addr), 32'd0);
        check("rst5_min_val", 32'(min_val), 32'hFF);
        check("rst5_move_goalie", 32'(move_goalie), 32'd0);
        check("rst5_timeout_err", 32'(timeout_err), 32'd0);
        resetn = 1'b1;
        mon_reset();
        guard = 0;
        while (guard < 200 && bus.sample_we !== 1'b1) begin
            @(negedge clk);
            guard++;
        end
        check("restart_first_we", 32'(bus.sample_we), 32'd1);
        check("restart_addr", 32'(bus.sample_addr), 32'd0);
        check("restart_data", 32'(bus.sample_data), 32'd120);
        check("restart_no_frame", 32'(fv_count), 32'd0);
        enable = 1'b0;
        wait_frame(-1, cyc, seen);
        check("restart_min_addr", 32'(min_addr), 32'd3);
        check("restart_min_val", 32'(min_val), 32'd60);
        check("restart_move_goalie", 32'(move_goalie), 32'd1);
        repeat (30) @(negedge clk);
        check_strobes(vecs[0].data, 8'h00);
        check("restart_frame_pulses", 32'(fv_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
